// File: rtl/uc_soma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uc_soma_pkg
// Brief    : Shared types and constants for the FP32 add control unit.
// Revision : 1.0 - initial release
// ============================================================================
package uc_soma_pkg;

    localparam int N_EXP_DEF  = 8;
    localparam int N_MANT_DEF = 23;
    localparam int LZ_W       = 5;
    localparam int SHIFT_SAT  = N_MANT_DEF + 2;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;
    localparam logic EXP_INC     = 1'b0;
    localparam logic EXP_DEC     = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ADD    = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        RENORM = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uc_abs_sat.sv
`default_nettype none
// ============================================================================
// Module   : uc_abs_sat
// Brief    : Two's-complement magnitude of an exponent difference, saturated.
// Revision : 1.0 - initial release
// ============================================================================
module uc_abs_sat
    import uc_soma_pkg::*;
#(
    parameter int N_EXP = N_EXP_DEF,
    parameter int OUT_W = LZ_W,
    parameter int SAT   = SHIFT_SAT
) (
    input  logic [N_EXP-1:0] i_diff,
    output logic [OUT_W-1:0] o_amount
);

    localparam logic [N_EXP-1:0] c_sat = N_EXP'(SAT);

    logic [N_EXP-1:0] w_neg;
    logic [N_EXP-1:0] w_mag;

    // The most-negative input negates to itself; read unsigned it is 2^(N-1),
    // which is above the saturation point, so it clamps like any large shift.
    assign w_neg    = -i_diff;
    assign w_mag    = i_diff[N_EXP-1] ? w_neg : i_diff;
    assign o_amount = (w_mag > c_sat) ? OUT_W'(c_sat) : OUT_W'(w_mag);

endmodule
`default_nettype wire

// File: rtl/uc_soma.sv
`default_nettype none
// ============================================================================
// Module   : uc_soma
// Brief    : Control unit sequencing align/add/normalize/round for FP32 add.
// Revision : 1.0 - initial release
// ============================================================================
module uc_soma #(
    parameter int N_exp  = 8,
    parameter int N_mant = 23,
    parameter int LZ_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_exp-1:0] diferenca_exp,
    input  logic             mant_ovf,
    input  logic             sum_zero,
    input  logic [LZ_W-1:0]  lead_zeros,
    input  logic             round_carry,
    output logic             ld_op,
    output logic             ld_sum,
    output logic             ld_res,
    output logic             BigAlu_in_A,
    output logic             BigAlu_in_B,
    output logic [LZ_W-1:0]  ShiftDif_amount,
    output logic             Exp_sel,
    output logic             ShiftNorm_sel,
    output logic [LZ_W-1:0]  ShiftNorm_amount,
    output logic             Increment_sel,
    output logic [LZ_W-1:0]  Increment_amount,
    output logic             Roud_amount,
    output logic             busy,
    output logic             done
);

    import uc_soma_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic              r_swap;
    logic [LZ_W-1:0]   r_shamt;
    logic              w_swap;
    logic [LZ_W-1:0]   w_shamt;

    assign w_swap = diferenca_exp[N_exp-1];

    uc_abs_sat #(
        .N_EXP (N_exp),
        .OUT_W (LZ_W),
        .SAT   (N_mant + 2)
    ) u_abs_sat (
        .i_diff   (diferenca_exp),
        .o_amount (w_shamt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_swap  <= 1'b0;
            r_shamt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ALIGN) begin
                r_swap  <= w_swap;
                r_shamt <= w_shamt;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        ld_op            = 1'b0;
        ld_sum           = 1'b0;
        ld_res           = 1'b0;
        BigAlu_in_A      = 1'b0;
        BigAlu_in_B      = 1'b0;
        ShiftDif_amount  = '0;
        Exp_sel          = 1'b0;
        ShiftNorm_sel    = SHIFT_LEFT;
        ShiftNorm_amount = '0;
        Increment_sel    = EXP_INC;
        Increment_amount = '0;
        Roud_amount      = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    ld_op  = 1'b1;
                    w_next = ALIGN;
                end
            end
            // Selects come straight from the live difference here and are
            // held from the captured copy during ADD.
            ALIGN: begin
                busy            = 1'b1;
                BigAlu_in_A     = w_swap;
                BigAlu_in_B     = ~w_swap;
                Exp_sel         = w_swap;
                ShiftDif_amount = w_shamt;
                w_next          = ADD;
            end
            ADD: begin
                busy            = 1'b1;
                BigAlu_in_A     = r_swap;
                BigAlu_in_B     = ~r_swap;
                Exp_sel         = r_swap;
                ShiftDif_amount = r_shamt;
                ld_sum          = 1'b1;
                w_next          = NORM;
            end
            NORM: begin
                busy = 1'b1;
                if (sum_zero) begin
                    ld_res = 1'b1;
                    w_next = DONE;
                end else begin
                    ld_sum = 1'b1;
                    w_next = ROUND;
                    if (mant_ovf) begin
                        ShiftNorm_sel    = SHIFT_RIGHT;
                        ShiftNorm_amount = LZ_W'(1);
                        Increment_sel    = EXP_INC;
                        Increment_amount = LZ_W'(1);
                    end else begin
                        ShiftNorm_sel    = SHIFT_LEFT;
                        ShiftNorm_amount = lead_zeros;
                        Increment_sel    = EXP_DEC;
                        Increment_amount = lead_zeros;
                    end
                end
            end
            ROUND: begin
                busy        = 1'b1;
                Roud_amount = 1'b1;
                ld_sum      = 1'b1;
                if (round_carry) begin
                    w_next = RENORM;
                end else begin
                    ld_res = 1'b1;
                    w_next = DONE;
                end
            end
            RENORM: begin
                busy             = 1'b1;
                ShiftNorm_sel    = SHIFT_RIGHT;
                ShiftNorm_amount = LZ_W'(1);
                Increment_sel    = EXP_INC;
                Increment_amount = LZ_W'(1);
                ld_res           = 1'b1;
                w_next           = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire
